hilo_divider: RTL

HILO_DIVIDER -- requirements
Module: hilo_divider

---
 rtl/hilo_divider.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hilo_divider.sv
// Iterative restoring divider for the HI/LO unit: one quotient bit per cycle,
// DIV/DIVU with sign fix-up, divide-by-zero bypass and pipeline-flush cancel.
module hilo_divider #(
  parameter int WIDTH       = 32,
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             negQ;
  logic             negR;
  logic             zeroDiv;

  logic             negA;
  logic             negB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             accept;
  logic             finish;
  logic             stepEn;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign negA = is_signed & a[WIDTH-1];
  assign negB = is_signed & b[WIDTH-1];
  assign magA = negA ? -a : a;
  assign magB = negB ? -b : b;

  assign accept = start & ~cancel & (state != CALC);
  assign finish = (state == CALC) & ~cancel
                & (zeroDiv | (count == '0));
  assign stepEn = (state == CALC) & ~cancel
                & ~zeroDiv & (count != '0);

  // Partial remainder stays below the divisor, so W bits hold it.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (accept) stateNext = CALC;
      end
      CALC: begin
        if (cancel) begin
          stateNext = IDLE;
        end else if (finish) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = accept ? CALC : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      negQ        <= 1'b0;
      negR        <= 1'b0;
      zeroDiv     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        count   <= CW'(WIDTH);
        rem     <= '0;
        dvs     <= magB;
        negQ    <= negA ^ negB;
        negR    <= negA;
        zeroDiv <= (b == '0);
        // A zero divisor reports the raw dividend, so keep it unmodified.
        quo     <= (b == '0) ? a : magA;
      end else if (stepEn) begin
        count <= count - CW'(1);
        if (!trial[WIDTH]) begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end

      if (finish) begin
        if (zeroDiv) begin
          quotient    <= '1;
          remainder   <= quo;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= negQ ? -quo : quo;
          remainder   <= negR ? -rem : rem;
          div_by_zero <= 1'b0;
        end
      end else if (!HOLD_RESULT && (state == DONE)) begin
        quotient  <= '0;
        remainder <= '0;
      end
    end
  end

endmodule
